// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 7;

  // Active-low glyphs, bit order {a,b,c,d,e,f,g}
  localparam logic [SEG_W-1:0] GLYPH_0   = 7'b0000001;
  localparam logic [SEG_W-1:0] GLYPH_1   = 7'b1001111;
  localparam logic [SEG_W-1:0] GLYPH_2   = 7'b0010010;
  localparam logic [SEG_W-1:0] GLYPH_3   = 7'b0000110;
  localparam logic [SEG_W-1:0] GLYPH_4   = 7'b1001100;
  localparam logic [SEG_W-1:0] GLYPH_5   = 7'b0100100;
  localparam logic [SEG_W-1:0] GLYPH_6   = 7'b0100000;
  localparam logic [SEG_W-1:0] GLYPH_7   = 7'b0001111;
  localparam logic [SEG_W-1:0] GLYPH_8   = 7'b0000000;
  localparam logic [SEG_W-1:0] GLYPH_9   = 7'b0000100;
  localparam logic [SEG_W-1:0] GLYPH_OFF = 7'b1111111;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } scan_state_e;

  // One complete display frame: four BCD digits plus their decimal points
  typedef struct packed {
    logic [NUM_DIGITS*NIB_W-1:0] value;
    logic [NUM_DIGITS-1:0]       dp;
  } frame_t;

endpackage

// File: rtl/seg7_decode.sv
// BCD nibble to active-low 7-segment glyph; non-decimal codes render as "0".
module seg7_decode
  import seg_pkg::*;
(
  input  logic [NIB_W-1:0] nibble_i,
  output logic [SEG_W-1:0] glyph_c_o
);

  always_comb begin
    glyph_c_o = GLYPH_0;
    case (nibble_i)
      4'd0:    glyph_c_o = GLYPH_0;
      4'd1:    glyph_c_o = GLYPH_1;
      4'd2:    glyph_c_o = GLYPH_2;
      4'd3:    glyph_c_o = GLYPH_3;
      4'd4:    glyph_c_o = GLYPH_4;
      4'd5:    glyph_c_o = GLYPH_5;
      4'd6:    glyph_c_o = GLYPH_6;
      4'd7:    glyph_c_o = GLYPH_7;
      4'd8:    glyph_c_o = GLYPH_8;
      4'd9:    glyph_c_o = GLYPH_9;
      default: glyph_c_o = GLYPH_0;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with dead-time between digits and
// a shadow register so new values only take effect at a frame boundary.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [NUM_DIGITS*NIB_W-1:0] value,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic                        blank_lz,
  output logic                        ld_ready,
  output logic [SEG_W-1:0]            seg,
  output logic                        dp,
  output logic [NUM_DIGITS-1:0]       an
);

  localparam int unsigned SHOW_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BLANK_W = 8;
  localparam int unsigned IDX_W   = 2;
  localparam logic [SHOW_W-1:0]  SHOW_LAST  = SHOW_W'(CLK_DIV - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_e           state_q, state_d;
  logic [SHOW_W-1:0]     show_cnt_q, show_cnt_d;
  logic [BLANK_W-1:0]    blank_cnt_q, blank_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  frame_t                active_q, active_d;
  frame_t                shadow_q, shadow_d;
  logic                  ready_q, ready_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  accept_c;
  logic [NIB_W-1:0]      nibble_c;
  logic [SEG_W-1:0]      glyph_c;
  logic [NUM_DIGITS-1:0] zero_c;
  logic [NUM_DIGITS-1:0] lz_mask_c;
  logic                  lz_blank_c;

  assign nibble_c = active_q.value[{idx_q, 2'b00} +: NIB_W];

  seg7_decode u_decode (
    .nibble_i  (nibble_c),
    .glyph_c_o (glyph_c)
  );

  // Digit k is a leading zero when it and every digit above it are zero; digit 0 never is
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      zero_c[k] = (active_q.value[k*NIB_W +: NIB_W] == '0);
    end
    lz_mask_c[NUM_DIGITS-1] = zero_c[NUM_DIGITS-1];
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      lz_mask_c[k] = zero_c[k] & lz_mask_c[k+1];
    end
    lz_mask_c[0] = 1'b0;
    lz_blank_c   = blank_lz & lz_mask_c[idx_q];
  end

  assign accept_c = load & ready_q;

  always_comb begin
    state_d     = state_q;
    show_cnt_d  = show_cnt_q;
    blank_cnt_d = blank_cnt_q;
    idx_d       = idx_q;
    active_d    = active_q;
    shadow_d    = shadow_q;
    ready_d     = ready_q;
    seg_d       = GLYPH_OFF;
    dp_d        = 1'b1;
    an_d        = '1;

    case (state_q)
      ST_SHOW: begin
        an_d  = ~(NUM_DIGITS'(1) << idx_q);
        seg_d = lz_blank_c ? GLYPH_OFF : glyph_c;
        dp_d  = ~active_q.dp[idx_q];
        if (show_cnt_q == SHOW_LAST) begin
          state_d     = ST_BLANK;
          show_cnt_d  = '0;
          blank_cnt_d = '0;
        end else begin
          show_cnt_d = show_cnt_q + 1'b1;
        end
      end
      ST_BLANK: begin
        if (blank_cnt_q == BLANK_LAST) begin
          state_d     = ST_SHOW;
          idx_d       = idx_q + 1'b1;
          show_cnt_d  = '0;
          blank_cnt_d = '0;
          // Frame boundary: the only point where a pending value becomes visible
          if (idx_q == IDX_LAST) begin
            if (!ready_q) begin
              active_d = shadow_q;
            end
            ready_d = 1'b1;
          end
        end else begin
          blank_cnt_d = blank_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_BLANK;
    endcase

    // A capture on the apply cycle lands after the copy and keeps pending set
    if (accept_c) begin
      shadow_d = '{value: value, dp: dp_in};
      ready_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BLANK;
      show_cnt_q  <= '0;
      blank_cnt_q <= '0;
      idx_q       <= IDX_LAST;
      active_q    <= '0;
      shadow_q    <= '0;
      ready_q     <= 1'b1;
      seg_q       <= GLYPH_OFF;
      dp_q        <= 1'b1;
      an_q        <= '1;
    end else begin
      state_q     <= state_d;
      show_cnt_q  <= show_cnt_d;
      blank_cnt_q <= blank_cnt_d;
      idx_q       <= idx_d;
      active_q    <= active_d;
      shadow_q    <= shadow_d;
      ready_q     <= ready_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

  assign ld_ready = ready_q;
  assign seg      = seg_q;
  assign dp       = dp_q;
  assign an       = an_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with CLK_DIV=4, BLANK_CYCLES=2.
module tb_seg_scan_ctrl;

  localparam logic [6:0] G0   = 7'b0000001;
  localparam logic [6:0] G1   = 7'b1001111;
  localparam logic [6:0] G2   = 7'b0010010;
  localparam logic [6:0] G3   = 7'b0000110;
  localparam logic [6:0] G4   = 7'b1001100;
  localparam logic [6:0] G7   = 7'b0001111;
  localparam logic [6:0] GOFF = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic        ld_ready;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int n_checks = 0;
  int n_pass   = 0;

  seg_scan_ctrl #(
    .CLK_DIV      (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .value    (value),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .ld_ready (ld_ready),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_an(input logic [3:0] target, input string tag);
    int n = 0;
    while (an !== target && n < 80) begin
      step();
      n++;
    end
    check(tag, 32'(an), 32'(target));
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ld_ready !== 1'b1 && n < 80) begin
      step();
      n++;
    end
    check(tag, 32'(ld_ready), 32'd1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load  = 1'b1;
    value = v;
    dp_in = d;
    step();
    load  = 1'b0;
  endtask

  logic [3:0] an_seq [14] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF,
                              4'hF, 4'hD, 4'hD, 4'hD, 4'hD, 4'hF, 4'hF};

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    value    = '0;
    dp_in    = '0;
    blank_lz = 1'b0;

    // Reset state
    step();
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'(GOFF));
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_ready", 32'(ld_ready), 32'd1);
    rst = 1'b0;

    // Idle scan after reset: blank x2, digit0 x4, blank x2, digit1 x4, blank x2
    for (int i = 0; i < 14; i++) begin
      step();
      check($sformatf("scan_an_%0d", i), 32'(an), 32'(an_seq[i]));
      if (an_seq[i] != 4'hF) begin
        check($sformatf("scan_seg_%0d", i), 32'(seg), 32'(G0));
      end else begin
        check($sformatf("scan_blank_seg_%0d", i), 32'(seg), 32'(GOFF));
      end
    end

    // Mid-frame load, then a second load while pending that must be ignored
    do_load(16'h1234, 4'b0000);
    check("ld_ready_fall", 32'(ld_ready), 32'd0);
    do_load(16'h5678, 4'b1111);
    check("ld_ignored_ready", 32'(ld_ready), 32'd0);
    wait_an(4'hE, "f1234_an0");
    check("f1234_seg0", 32'(seg), 32'(G4));
    check("f1234_dp0", 32'(dp), 32'd1);
    check("f1234_ready", 32'(ld_ready), 32'd1);
    wait_an(4'hD, "f1234_an1");
    check("f1234_seg1", 32'(seg), 32'(G3));
    wait_an(4'hB, "f1234_an2");
    check("f1234_seg2", 32'(seg), 32'(G2));
    wait_an(4'h7, "f1234_an3");
    check("f1234_seg3", 32'(seg), 32'(G1));
    check("f1234_dp3", 32'(dp), 32'd1);

    // Leading-zero blanking on 0070, then blanking disabled live
    blank_lz = 1'b1;
    do_load(16'h0070, 4'b0000);
    wait_ready("lz_apply");
    wait_an(4'hE, "lz_an0");
    check("lz_seg0", 32'(seg), 32'(G0));
    wait_an(4'hD, "lz_an1");
    check("lz_seg1", 32'(seg), 32'(G7));
    wait_an(4'hB, "lz_an2");
    check("lz_seg2", 32'(seg), 32'(GOFF));
    wait_an(4'h7, "lz_an3");
    check("lz_seg3", 32'(seg), 32'(GOFF));
    blank_lz = 1'b0;
    wait_an(4'hB, "nolz_an2");
    check("nolz_seg2", 32'(seg), 32'(G0));
    wait_an(4'h7, "nolz_an3");
    check("nolz_seg3", 32'(seg), 32'(G0));

    // Out-of-range nibble on digit 2 with its decimal point
    do_load(16'h0C00, 4'b0100);
    wait_ready("dp_apply");
    wait_an(4'hE, "dp_an0");
    check("dp_dp0", 32'(dp), 32'd1);
    wait_an(4'hD, "dp_an1");
    check("dp_dp1", 32'(dp), 32'd1);
    wait_an(4'hB, "dp_an2");
    check("dp_seg2", 32'(seg), 32'(G0));
    check("dp_dp2", 32'(dp), 32'd0);
    wait_an(4'h7, "dp_an3");
    check("dp_seg3", 32'(seg), 32'(G0));
    check("dp_dp3", 32'(dp), 32'd1);

    // Reset during digit-2 SHOW with a load pending
    wait_an(4'hE, "mr_an0");
    wait_an(4'hB, "mr_an2");
    do_load(16'h8888, 4'b1111);
    check("mr_pending", 32'(ld_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr_an", 32'(an), 32'hF);
    check("mr_ready", 32'(ld_ready), 32'd1);
    check("mr_seg", 32'(seg), 32'(GOFF));
    step();
    check("mr_blank1", 32'(an), 32'hF);
    step();
    check("mr_blank2", 32'(an), 32'hF);
    step();
    check("mr_d0_an", 32'(an), 32'hE);
    check("mr_d0_seg", 32'(seg), 32'(G0));
    check("mr_d0_dp", 32'(dp), 32'd1);
    wait_an(4'h7, "mr_an3");
    check("mr_discard_seg3", 32'(seg), 32'(G0));
    wait_an(4'hE, "mr_next_an0");
    check("mr_discard_seg0", 32'(seg), 32'(G0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
